// File: rtl/ssp_pkg.sv
// rtl/ssp_pkg.sv - shared SSP constants and types
// Purpose: word width, FIFO depth and pointer width shared by the SSP TX and RX FIFOs.
// Ports: none (package).
package ssp_pkg;

  localparam int SSP_DATA_W     = 8;
  localparam int SSP_FIFO_DEPTH = 8;
  localparam int SSP_FIFO_AW    = $clog2(SSP_FIFO_DEPTH);

  typedef logic [7:0] ssp_byte_t;

endpackage

// File: rtl/ssp_fifo_ptr.sv
// rtl/ssp_fifo_ptr.sv - pointer, count and flag controller for the SSP FIFOs
// Purpose: tracks write/read pointers and occupancy for a power-of-two FIFO.
// Ports:
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset
//   push_i     qualified push (caller has already checked full/pop)
//   pop_i      qualified pop (caller has already checked empty)
//   wr_ptr_o   write pointer
//   rd_ptr_o   read pointer
//   count_o    number of entries held
//   empty_o    count == 0
//   full_o     count == DEPTH
module ssp_fifo_ptr
  import ssp_pkg::*;
#(
  parameter int DEPTH  = SSP_FIFO_DEPTH,
  parameter int ADDR_W = SSP_FIFO_AW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  output logic [ADDR_W-1:0] wr_ptr_o,
  output logic [ADDR_W-1:0] rd_ptr_o,
  output logic [ADDR_W:0]   count_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;

  // DEPTH is a power of two, so natural overflow of the pointer gives the wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_i && !pop_i)      count_d = count_q + 1'b1;
    else if (pop_i && !push_i) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == DEPTH_C);

endmodule

// File: rtl/ssp_tx_fifo.sv
// rtl/ssp_tx_fifo.sv - SSP transmit FIFO
// Purpose: APB-written, first-word-fall-through byte FIFO feeding the SSP shifter.
// Optional: define SSP_TX_FIFO_ERR_EN to add sticky TxOVF / TxUNF error outputs.
// Ports:
//   PCLK       clock
//   CLEAR_B    asynchronous active-low reset
//   PSEL       APB select of the TX data register
//   PWRITE     APB write; push when PSEL & PWRITE and space (or a same-cycle pop)
//   PWDATA     byte to push
//   TxPOP      pop strobe from the transmit shifter
//   TxDATA     head byte, 0 when empty
//   TxEMPTY    no entries
//   TxFULL     DEPTH entries
//   SSPTXINTR  count <= DEPTH/2
//   TxCOUNT    occupancy
//   TxOVF      (SSP_TX_FIFO_ERR_EN) sticky dropped-push flag
//   TxUNF      (SSP_TX_FIFO_ERR_EN) sticky pop-while-empty flag
module ssp_tx_fifo
  import ssp_pkg::*;
#(
  parameter int DATA_W = SSP_DATA_W,
  parameter int DEPTH  = SSP_FIFO_DEPTH,
  parameter int ADDR_W = SSP_FIFO_AW
) (
  input  logic              PCLK,
  input  logic              CLEAR_B,
  input  logic              PSEL,
  input  logic              PWRITE,
  input  logic [DATA_W-1:0] PWDATA,
  input  logic              TxPOP,
  output logic [DATA_W-1:0] TxDATA,
  output logic              TxEMPTY,
  output logic              TxFULL,
  output logic              SSPTXINTR,
`ifdef SSP_TX_FIFO_ERR_EN
  output logic              TxOVF,
  output logic              TxUNF,
`endif
  output logic [ADDR_W:0]   TxCOUNT
);

  localparam logic [ADDR_W:0] HALF_C = (ADDR_W+1)'(DEPTH / 2);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              empty, full;
  logic              wr_req, pop_ok, push_ok;

  assign wr_req  = PSEL & PWRITE;
  assign pop_ok  = TxPOP & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign push_ok = wr_req & (~full | pop_ok);

  ssp_fifo_ptr #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ptr (
    .clk_i    (PCLK),
    .rst_ni   (CLEAR_B),
    .push_i   (push_ok),
    .pop_i    (pop_ok),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .count_o  (count),
    .empty_o  (empty),
    .full_o   (full)
  );

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr] <= PWDATA;
    end
  end

  // Stale entries stay in storage after a pop, so mask the head when empty.
  assign TxDATA    = empty ? '0 : mem_q[rd_ptr];
  assign TxEMPTY   = empty;
  assign TxFULL    = full;
  assign TxCOUNT   = count;
  assign SSPTXINTR = (count <= HALF_C);

`ifdef SSP_TX_FIFO_ERR_EN
  logic ovf_q, unf_q;

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_req && full && !pop_ok) ovf_q <= 1'b1;
      if (TxPOP && empty)            unf_q <= 1'b1;
    end
  end

  assign TxOVF = ovf_q;
  assign TxUNF = unf_q;
`endif

endmodule

// File: tb/tb_ssp_tx_fifo.sv
// tb/tb_ssp_tx_fifo.sv - directed self-checking bench for ssp_tx_fifo
module tb_ssp_tx_fifo;

  logic       PCLK = 1'b0;
  logic       CLEAR_B = 1'b0;
  logic       PSEL = 1'b0;
  logic       PWRITE = 1'b0;
  logic [7:0] PWDATA = 8'h00;
  logic       TxPOP = 1'b0;
  logic [7:0] TxDATA;
  logic       TxEMPTY, TxFULL, SSPTXINTR;
  logic [3:0] TxCOUNT;
`ifdef SSP_TX_FIFO_ERR_EN
  logic       TxOVF, TxUNF;
`endif

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  ssp_tx_fifo dut (
    .PCLK      (PCLK),
    .CLEAR_B   (CLEAR_B),
    .PSEL      (PSEL),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .TxPOP     (TxPOP),
    .TxDATA    (TxDATA),
    .TxEMPTY   (TxEMPTY),
    .TxFULL    (TxFULL),
    .SSPTXINTR (SSPTXINTR),
`ifdef SSP_TX_FIFO_ERR_EN
    .TxOVF     (TxOVF),
    .TxUNF     (TxUNF),
`endif
    .TxCOUNT   (TxCOUNT)
  );

  // Advance one edge; inputs are changed and outputs sampled 1ns after it.
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_reset();
    PSEL = 0; PWRITE = 0; TxPOP = 0;
    #1 CLEAR_B = 0;
    #1 CLEAR_B = 1;
  endtask

  task automatic push_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      PSEL = 1; PWRITE = 1; PWDATA = first + 8'(i);
      step();
    end
    PSEL = 0; PWRITE = 0;
  endtask

  task automatic test_reset();
    PSEL = 0; PWRITE = 0; TxPOP = 0; CLEAR_B = 0;
    #2;
    checks++;
    if (TxCOUNT !== 4'd0 || TxEMPTY !== 1'b1 || TxFULL !== 1'b0 ||
        SSPTXINTR !== 1'b1 || TxDATA !== 8'h00) begin
      errors++;
      $display("FAIL reset: cnt=%0d empty=%b full=%b intr=%b data=%h want 0 1 0 1 00",
               TxCOUNT, TxEMPTY, TxFULL, SSPTXINTR, TxDATA);
    end
    CLEAR_B = 1;
  endtask

  task automatic test_push3();
    push_bytes(8'h01, 3);
    checks++;
    if (TxCOUNT !== 4'd3 || TxDATA !== 8'h01 || TxEMPTY !== 1'b0 || SSPTXINTR !== 1'b1) begin
      errors++;
      $display("FAIL push3: cnt=%0d data=%h empty=%b intr=%b want 3 01 0 1",
               TxCOUNT, TxDATA, TxEMPTY, SSPTXINTR);
    end
  endtask

  task automatic test_full_overflow();
    do_reset();
    push_bytes(8'h10, 8);
    checks++;
    if (TxFULL !== 1'b1 || TxCOUNT !== 4'd8 || SSPTXINTR !== 1'b0) begin
      errors++;
      $display("FAIL full: full=%b cnt=%0d intr=%b want 1 8 0", TxFULL, TxCOUNT, SSPTXINTR);
    end
    push_bytes(8'h55, 1);
    checks++;
    if (TxCOUNT !== 4'd8 || TxDATA !== 8'h10) begin
      errors++;
      $display("FAIL overflow_drop: cnt=%0d data=%h want 8 10", TxCOUNT, TxDATA);
    end
`ifdef SSP_TX_FIFO_ERR_EN
    checks++;
    if (TxOVF !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: got %b want 1", TxOVF);
    end
`endif
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (TxDATA !== 8'h10 + 8'(i)) begin
        errors++;
        $display("FAIL pop_order[%0d]: got %h want %h", i, TxDATA, 8'h10 + 8'(i));
      end
      TxPOP = 1;
      step();
      TxPOP = 0;
    end
    checks++;
    if (TxEMPTY !== 1'b1 || TxCOUNT !== 4'd0 || TxDATA !== 8'h00) begin
      errors++;
      $display("FAIL drained: empty=%b cnt=%0d data=%h want 1 0 00", TxEMPTY, TxCOUNT, TxDATA);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_bytes(8'h20, 8);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (TxDATA !== 8'h20 + 8'(i)) begin
        errors++;
        $display("FAIL wrap_order[%0d]: got %h want %h", i, TxDATA, 8'h20 + 8'(i));
      end
      PSEL = 1; PWRITE = 1; PWDATA = 8'h28 + 8'(i); TxPOP = 1;
      step();
    end
    PSEL = 0; PWRITE = 0; TxPOP = 0;
    checks++;
    if (TxCOUNT !== 4'd8 || TxFULL !== 1'b1 || TxDATA !== 8'h2C) begin
      errors++;
      $display("FAIL wrap_end: cnt=%0d full=%b data=%h want 8 1 2c", TxCOUNT, TxFULL, TxDATA);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    TxPOP = 1;
    step();
    TxPOP = 0;
    checks++;
    if (TxCOUNT !== 4'd0 || TxEMPTY !== 1'b1) begin
      errors++;
      $display("FAIL pop_empty: cnt=%0d empty=%b want 0 1", TxCOUNT, TxEMPTY);
    end
`ifdef SSP_TX_FIFO_ERR_EN
    checks++;
    if (TxUNF !== 1'b1) begin
      errors++;
      $display("FAIL unf_flag: got %b want 1", TxUNF);
    end
`endif
    PSEL = 1; PWRITE = 1; PWDATA = 8'hA5; TxPOP = 1;
    step();
    PSEL = 0; PWRITE = 0; TxPOP = 0;
    checks++;
    if (TxCOUNT !== 4'd1 || TxDATA !== 8'hA5) begin
      errors++;
      $display("FAIL push_pop_empty: cnt=%0d data=%h want 1 a5", TxCOUNT, TxDATA);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    push_bytes(8'h40, 4);
    #2 CLEAR_B = 0;
    #1;
    checks++;
    if (TxCOUNT !== 4'd0 || TxEMPTY !== 1'b1 || SSPTXINTR !== 1'b1 || TxDATA !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: cnt=%0d empty=%b intr=%b data=%h want 0 1 1 00",
               TxCOUNT, TxEMPTY, SSPTXINTR, TxDATA);
    end
    #1 CLEAR_B = 1;
    push_bytes(8'h3C, 1);
    checks++;
    if (TxCOUNT !== 4'd1 || TxDATA !== 8'h3C) begin
      errors++;
      $display("FAIL post_reset_push: cnt=%0d data=%h want 1 3c", TxCOUNT, TxDATA);
    end
  endtask

  task automatic test_intr_threshold();
    do_reset();
    push_bytes(8'h50, 4);
    checks++;
    if (SSPTXINTR !== 1'b1 || TxCOUNT !== 4'd4) begin
      errors++;
      $display("FAIL intr_at4: intr=%b cnt=%0d want 1 4", SSPTXINTR, TxCOUNT);
    end
    PSEL = 1; PWRITE = 1; PWDATA = 8'h54;
    #1;
    checks++;
    if (SSPTXINTR !== 1'b1) begin
      errors++;
      $display("FAIL intr_before_edge: got %b want 1", SSPTXINTR);
    end
    @(posedge PCLK); #1;
    PSEL = 0; PWRITE = 0;
    checks++;
    if (SSPTXINTR !== 1'b0 || TxCOUNT !== 4'd5) begin
      errors++;
      $display("FAIL intr_at5: intr=%b cnt=%0d want 0 5", SSPTXINTR, TxCOUNT);
    end
    TxPOP = 1;
    step();
    TxPOP = 0;
    checks++;
    if (SSPTXINTR !== 1'b1 || TxCOUNT !== 4'd4 || TxDATA !== 8'h51) begin
      errors++;
      $display("FAIL intr_back4: intr=%b cnt=%0d data=%h want 1 4 51", SSPTXINTR, TxCOUNT, TxDATA);
    end
  endtask

  initial begin
    test_reset();
    test_push3();
    test_full_overflow();
    test_back_to_back();
    test_underflow();
    test_async_reset();
    test_intr_threshold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ssp_tx_fifo.md
Name: ssp_tx_fifo

Overview:
Transmit-side FIFO of the SSP block, the counterpart of the receive FIFO. The APB write path pushes bytes from PWDATA; the transmit shift logic pops one byte per frame through a strobe. SSPTXINTR flags free space to the processor, and TxEMPTY tells the shifter there is nothing to send.

Parameters:
DATA_W, 8, width of each FIFO word.
DEPTH, 8, number of entries; power of two, at least 2.
ADDR_W, 3, pointer width, log2(DEPTH).

Ports:
PCLK  input  1  system clock; all state updates on the rising edge.
CLEAR_B  input  1  asynchronous active-low reset; clears pointers, count, flags and storage.
PSEL  input  1  APB select for the TX data register.
PWRITE  input  1  APB write strobe; a push needs PSEL & PWRITE.
PWDATA  input  DATA_W  byte written by the processor.
TxPOP  input  1  single-cycle pop request from the transmit logic.
TxDATA  output  DATA_W  head-of-FIFO byte (first-word-fall-through).
TxEMPTY  output  1  FIFO holds no entries.
TxFULL  output  1  FIFO holds DEPTH entries.
SSPTXINTR  output  1  TX interrupt; high while count <= DEPTH/2.
TxCOUNT  output  ADDR_W+1  current number of entries.

Behaviour:
- Reset (CLEAR_B low, asynchronous): wr_ptr = rd_ptr = 0; TxCOUNT = 0; TxEMPTY = 1; TxFULL = 0; SSPTXINTR = 1; TxDATA = 0; storage cleared. Release is synchronous to PCLK; the first push can occur on the first rising edge after release.
- Push condition: PSEL & PWRITE & (!TxFULL | pop_ok). The write is level-sensitive, so one byte is pushed per PCLK edge while the condition holds.
- Pop condition: pop_ok = TxPOP & !TxEMPTY.
- Push: mem[wr_ptr] <= PWDATA; wr_ptr increments modulo DEPTH and wraps from DEPTH-1 to 0.
- Pop: rd_ptr increments modulo DEPTH.
- TxDATA = mem[rd_ptr], presented combinationally from the registered pointer. It is valid whenever TxEMPTY = 0 and reads 0 when empty.
- Latency: a byte pushed at edge N is visible on TxDATA after edge N when the FIFO was empty; TxEMPTY falls after the same edge.
- Count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Flags: TxEMPTY = (count == 0); TxFULL = (count == DEPTH); SSPTXINTR = (count <= DEPTH/2). All are derived from the registered count, so there are no glitches inside a cycle.
- Boundary, push while full without a pop: the write is dropped; pointers, count and storage are unchanged.
- Boundary, push and pop while full: both are performed; count stays at DEPTH; the oldest byte leaves and the new byte enters.
- Boundary, pop while empty: ignored. If a push happens in the same cycle, only the push takes effect (no bypass) and count becomes 1.
- Boundary, pop while TxPOP is held high for several cycles: one entry is popped per cycle until empty.
- Reset mid-operation: all contents are discarded immediately and outputs return to their reset values without waiting for a clock edge.

Optional Feature:
Macro: SSP_TX_FIFO_ERR_EN.
- Defined: two extra outputs are added.
  - TxOVF: sticky; set by a dropped push (full, no pop).
  - TxUNF: sticky; set by TxPOP while empty.
  - Both are cleared only by CLEAR_B; reset value 0.
- Not defined: the ports and their logic are absent; dropped pushes and ignored pops are silent.

Decomposition:
- Shared package ssp_pkg holds:
  - constants SSP_DATA_W = 8 and SSP_FIFO_DEPTH = 8;
  - derived constant SSP_FIFO_AW = 3;
  - typedef ssp_byte_t (logic [7:0]).
- The RX FIFO uses the same package.
- One natural sub-module: ssp_fifo_ptr, a pointer/count/flag controller shared with the RX FIFO.
  - Inputs: push, pop.
  - Outputs: wr_ptr, rd_ptr, count, empty, full.
- Storage and the data mux stay in ssp_tx_fifo.

Test Plan:
1. Reset, then push 0x01, 0x02, 0x03 on three consecutive edges -> TxCOUNT = 3, TxDATA = 0x01, TxEMPTY = 0, SSPTXINTR = 1.
2. Push 0x10..0x17 (8 bytes), then attempt a push of 0x55 -> TxFULL = 1, TxCOUNT = 8, SSPTXINTR = 0, 0x55 dropped (TxOVF = 1 when SSP_TX_FIFO_ERR_EN is defined); eight single-cycle pops return 0x10..0x17 in order.
3. Keep the FIFO at 8 with simultaneous push and pop for 12 cycles of incrementing data -> count stays 8 and output order is preserved across pointer wrap-around.
4. Empty FIFO, TxPOP pulse -> TxCOUNT stays 0 and TxEMPTY stays 1 (TxUNF = 1 when the macro is defined). Then a simultaneous push of 0xA5 and pop -> TxCOUNT = 1, TxDATA = 0xA5.
5. Load 4 bytes, then pull CLEAR_B low mid-cycle between edges -> TxCOUNT = 0, TxEMPTY = 1, SSPTXINTR = 1 immediately. A push of 0x3C after release reads back 0x3C.
6. Count crossing 4 -> 5 -> 4 -> SSPTXINTR goes 1 -> 0 -> 1, aligned with the PCLK edge.
